// File: rtl/sram_bus_master_if.sv
// Bundles the core request port and the asynchronous byte-wide SRAM pins for sram_bus_master.
// The master modport is the controller's view and the slave modport is the core/SRAM side.
interface sram_bus_master_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  REQ;
    logic                  WR;
    logic [ADDR_WIDTH-1:0] ADDR;
    logic [7:0]            WDATA;
    logic                  READY;
    logic                  RVALID;
    logic [7:0]            RDATA;
    logic [ADDR_WIDTH-1:0] A;
    logic [7:0]            D;
    logic [7:0]            Q;
    logic                  CS_bar;
    logic                  OE_bar;
    logic                  WE_bar;

    modport master (
        input  REQ, WR, ADDR, WDATA, Q,
        output READY, RVALID, RDATA, A, D, CS_bar, OE_bar, WE_bar
    );

    modport slave (
        output REQ, WR, ADDR, WDATA, Q,
        input  READY, RVALID, RDATA, A, D, CS_bar, OE_bar, WE_bar
    );
endinterface

// File: rtl/sram_bus_master.sv
// Sequences single-cycle core requests into SETUP/ACCESS/HOLD cycles on an asynchronous SRAM.
// Optional macro SRAM_MASTER_FAST_READ_EN: reads return to IDLE on the capture edge and skip HOLD.
module sram_bus_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 2
) (
    input  logic              CLK,
    input  logic              RST_bar,
    sram_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] RD_WAIT = 4'(READ_WAIT);
    localparam logic [3:0] WR_WAIT = 4'(WRITE_WAIT);

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic                  wr_q;
    logic                  cs_n, oe_n, we_n;
    logic                  cs_n_nx, oe_n_nx, we_n_nx;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [7:0]            d_q;
    logic [7:0]            rdata_q;
    logic                  rvalid_q;
    logic                  accept;
    logic                  capture;

    assign accept  = bus.REQ && (state == IDLE);
    assign capture = (state == ACCESS) && (cnt == 4'd0) && !wr_q;

    // Strobes are computed for the state being entered, so every SRAM pin comes straight from a flop.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cs_n_nx  = 1'b1;
        oe_n_nx  = 1'b1;
        we_n_nx  = 1'b1;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SETUP;
                    cs_n_nx  = 1'b0;
                    oe_n_nx  = bus.WR;
                end
            end
            SETUP: begin
                state_nx = ACCESS;
                cnt_nx   = wr_q ? WR_WAIT : RD_WAIT;
                cs_n_nx  = 1'b0;
                oe_n_nx  = wr_q;
                we_n_nx  = !wr_q;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
`ifdef SRAM_MASTER_FAST_READ_EN
                    state_nx = wr_q ? HOLD : IDLE;
`else
                    state_nx = HOLD;
`endif
                    // Writes keep CS low through HOLD so A/D are held past the WE rising edge.
                    cs_n_nx  = !wr_q;
                end else begin
                    cnt_nx  = cnt - 4'd1;
                    cs_n_nx = 1'b0;
                    oe_n_nx = wr_q;
                    we_n_nx = !wr_q;
                end
            end
            HOLD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state <= IDLE;
            cnt   <= 4'd0;
            wr_q  <= 1'b0;
            cs_n  <= 1'b1;
            oe_n  <= 1'b1;
            we_n  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cs_n  <= cs_n_nx;
            oe_n  <= oe_n_nx;
            we_n  <= we_n_nx;
            if (accept) begin
                wr_q <= bus.WR;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            a_q      <= '0;
            d_q      <= 8'd0;
            rdata_q  <= 8'd0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= capture;
            if (capture) begin
                rdata_q <= bus.Q;
            end
            if (accept) begin
                a_q <= bus.ADDR;
                d_q <= bus.WDATA;
            end
        end
    end

    assign bus.READY  = (state == IDLE);
    assign bus.RVALID = rvalid_q;
    assign bus.RDATA  = rdata_q;
    assign bus.A      = a_q;
    assign bus.D      = d_q;
    assign bus.CS_bar = cs_n;
    assign bus.OE_bar = oe_n;
    assign bus.WE_bar = we_n;
endmodule

// File: tb/tb_sram_bus_master.sv
// Scoreboard bench for sram_bus_master: one instance with 2 wait states, one with 0, each on its own SRAM model.
// Expected read data and RVALID cycle are queued at the accept edge and popped when RVALID is seen.
module tb_sram_bus_master;
    localparam int AW  = 15;
    localparam int RW0 = 2;
    localparam int WW0 = 2;
`ifdef SRAM_MASTER_FAST_READ_EN
    localparam int RD_PERIOD = RW0 + 3;
`else
    localparam int RD_PERIOD = RW0 + 4;
`endif

    typedef struct {
        logic [7:0] data;
        int         at_cyc;
    } exp_t;

    logic CLK     = 1'b0;
    logic RST_bar = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    logic [7:0] mem0 [0:(1<<AW)-1];
    logic [7:0] mem1 [0:(1<<AW)-1];
    logic          prev_cs0 = 1'b1;
    logic [AW-1:0] prev_a0;
    logic [7:0]    prev_d0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    sram_bus_master_if #(.ADDR_WIDTH(AW)) bus0 ();
    sram_bus_master_if #(.ADDR_WIDTH(AW)) bus1 ();

    sram_bus_master #(.ADDR_WIDTH(AW), .READ_WAIT(RW0), .WRITE_WAIT(WW0)) dut0 (
        .CLK(CLK), .RST_bar(RST_bar), .bus(bus0));
    sram_bus_master #(.ADDR_WIDTH(AW), .READ_WAIT(0), .WRITE_WAIT(0)) dut1 (
        .CLK(CLK), .RST_bar(RST_bar), .bus(bus1));

    // SRAM models: read data only inside the CS/OE window, writes latched while WE is low.
    assign bus0.Q = (!bus0.CS_bar && !bus0.OE_bar) ? mem0[bus0.A] : 8'hxx;
    assign bus1.Q = (!bus1.CS_bar && !bus1.OE_bar) ? mem1[bus1.A] : 8'hxx;

    always @(negedge CLK) begin
        if (!RST_bar) mem0[0] <= 8'hFF;
        else if (!bus0.CS_bar && !bus0.WE_bar) mem0[bus0.A] <= bus0.D;
    end

    always @(negedge CLK) begin
        if (!bus1.CS_bar && !bus1.WE_bar) mem1[bus1.A] <= bus1.D;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        check("oe_we_excl0", 32'(bus0.OE_bar | bus0.WE_bar), 32'd1);
        check("oe_we_excl1", 32'(bus1.OE_bar | bus1.WE_bar), 32'd1);
        if (!prev_cs0 && !bus0.CS_bar) begin
            check("a_stable0", 32'(bus0.A), 32'(prev_a0));
            check("d_stable0", 32'(bus0.D), 32'(prev_d0));
        end
        prev_cs0 = bus0.CS_bar;
        prev_a0  = bus0.A;
        prev_d0  = bus0.D;
        if (bus0.RVALID) begin
            if (sb0.size() == 0) check("rvalid_spurious0", 32'd1, 32'd0);
            else begin
                e0 = sb0.pop_front();
                check("rdata0", 32'(bus0.RDATA), 32'(e0.data));
                check("rvalid_cyc0", 32'(cyc), 32'(e0.at_cyc));
            end
        end
        if (bus1.RVALID) begin
            if (sb1.size() == 0) check("rvalid_spurious1", 32'd1, 32'd0);
            else begin
                e1 = sb1.pop_front();
                check("rdata1", 32'(bus1.RDATA), 32'(e1.data));
                check("rvalid_cyc1", 32'(cyc), 32'(e1.at_cyc));
            end
        end
    end

    // Call away from a rising edge; leaves REQ high so back-to-back requests can be chained.
    task automatic req(input bit sel, input bit wr, input logic [AW-1:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_rd, output int acc);
        int   n = 0;
        exp_t e;
        acc = -1;
        while (!(sel ? bus1.READY : bus0.READY) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (sel) begin
            bus1.WR = wr; bus1.ADDR = addr; bus1.WDATA = wd; bus1.REQ = 1'b1;
        end else begin
            bus0.WR = wr; bus0.ADDR = addr; bus0.WDATA = wd; bus0.REQ = 1'b1;
        end
        @(posedge CLK);
        #1;
        acc = cyc;
        if (!wr) begin
            e.data   = exp_rd;
            e.at_cyc = acc + 2 + (sel ? 0 : RW0);
            if (sel) sb1.push_back(e);
            else     sb0.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        bus0.REQ = 1'b0; bus0.WR = 1'b0; bus0.ADDR = '0; bus0.WDATA = 8'd0;
        bus1.REQ = 1'b0; bus1.WR = 1'b0; bus1.ADDR = '0; bus1.WDATA = 8'd0;

        // Reset state, then a mid-cycle reset assertion while idle
        repeat (3) @(negedge CLK);
        RST_bar = 1'b1;
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #2 RST_bar = 1'b0;
        #1;
        check("rst_cs", 32'(bus0.CS_bar), 32'd1);
        check("rst_oe", 32'(bus0.OE_bar), 32'd1);
        check("rst_we", 32'(bus0.WE_bar), 32'd1);
        check("rst_ready", 32'(bus0.READY), 32'd1);
        check("rst_rvalid", 32'(bus0.RVALID), 32'd0);
        check("rst_a", 32'(bus0.A), 32'd0);
        check("rst_rdata", 32'(bus0.RDATA), 32'd0);
        @(negedge CLK);
        RST_bar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("idle_strobes", 32'({bus0.CS_bar, bus0.OE_bar, bus0.WE_bar}), 32'h7);
        end

        // Write 0xA5 to 0x1234: WE low exactly cycles 1..3 after accept, A/D held through HOLD
        req(1'b0, 1'b1, 15'h1234, 8'hA5, 8'h00, a1);
        bus0.REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("wr_a", 32'(bus0.A), 32'h1234);
            check("wr_d", 32'(bus0.D), 32'hA5);
            check("wr_cs", 32'(bus0.CS_bar), 32'd0);
            check("wr_we", 32'(bus0.WE_bar), (i >= 1 && i <= 3) ? 32'd0 : 32'd1);
        end
        @(negedge CLK);
        check("wr_done_cs", 32'(bus0.CS_bar), 32'd1);
        check("wr_done_ready", 32'(bus0.READY), 32'd1);
        req(1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5, a1);
        bus0.REQ = 1'b0;
        repeat (6) @(negedge CLK);

        // Back-to-back with REQ held: write 0x7FFF=0x01 then read preset 0x0000
        req(1'b0, 1'b1, 15'h7FFF, 8'h01, 8'h00, a1);
        req(1'b0, 1'b0, 15'h0000, 8'h00, 8'hFF, a2);
        bus0.REQ = 1'b0;
        check("b2b_wr_period", 32'(a2 - a1), 32'(WW0 + 4));
        repeat (6) @(negedge CLK);

        // Two consecutive reads: period depends on HOLD being skipped
        req(1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5, a1);
        req(1'b0, 1'b0, 15'h7FFF, 8'h00, 8'h01, a2);
        bus0.REQ = 1'b0;
        check("rd_rd_period", 32'(a2 - a1), 32'(RD_PERIOD));
        repeat (6) @(negedge CLK);

        // Zero wait states: single ACCESS cycle, RVALID two edges after accept
        req(1'b1, 1'b1, 15'h0042, 8'h3C, 8'h00, a1);
        bus1.REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("w0_we", 32'(bus1.WE_bar), (i == 1) ? 32'd0 : 32'd1);
            check("w0_cs", 32'(bus1.CS_bar), (i < 3) ? 32'd0 : 32'd1);
        end
        req(1'b1, 1'b0, 15'h0042, 8'h00, 8'h3C, a2);
        bus1.REQ = 1'b0;
        check("w0_period", 32'(a2 - a1), 32'd4);
        repeat (4) @(negedge CLK);

        // Reset during the ACCESS phase of a write
        req(1'b0, 1'b1, 15'h0000, 8'h00, 8'h00, a1);
        bus0.REQ = 1'b0;
        repeat (2) @(negedge CLK);
        check("abort_we_low", 32'(bus0.WE_bar), 32'd0);
        #2 RST_bar = 1'b0;
        #1;
        check("abort_we", 32'(bus0.WE_bar), 32'd1);
        check("abort_cs", 32'(bus0.CS_bar), 32'd1);
        check("abort_a", 32'(bus0.A), 32'd0);
        check("abort_d", 32'(bus0.D), 32'd0);
        @(negedge CLK);
        RST_bar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_ready", 32'(bus0.READY), 32'd1);
            check("post_rst_rvalid", 32'(bus0.RVALID), 32'd0);
        end
        req(1'b0, 1'b0, 15'h1234, 8'h00, 8'hA5, a1);
        bus0.REQ = 1'b0;
        repeat (10) @(negedge CLK);

        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
